// File: rtl/mul_issue_pipe.sv
// rtl/mul_issue_pipe.sv - two-stage RV32M MUL/MULH/MULHSU/MULHU pipe around an unsigned 32x32 multiplier
// Optional output-handshake counter (perf_ops) enabled by defining MUL_ISSUE_PERF_CNT_EN.

module Mul32U (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] prod
);
    assign prod = {32'd0, a} * {32'd0, b};
endmodule

module mul_issue_pipe #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_op1,
    input  logic [31:0]      in_op2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_res,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
`ifdef MUL_ISSUE_PERF_CNT_EN
    ,
    output logic [31:0]      perf_ops
`endif
);
    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    logic             s1Valid;
    logic [31:0]      s1Mag1;
    logic [31:0]      s1Mag2;
    logic             s1Neg;
    logic [1:0]       s1Op;
    logic [TAG_W-1:0] s1Tag;

    logic             s2Valid;
    logic [63:0]      s2Prod;
    logic [1:0]       s2Op;
    logic [TAG_W-1:0] s2Tag;

    logic        s1Adv;
    logic        s2Adv;
    logic        accept;
    logic        op1Neg;
    logic        op2Neg;
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic [63:0] prod;
    logic [63:0] prodFix;

    assign s2Adv    = !s2Valid || out_ready;
    assign s1Adv    = !s1Valid || s2Adv;
    assign in_ready = s1Adv && !flush;
    assign accept   = in_valid && in_ready;

    // op1 is signed for all but MULHU; op2 only for MUL/MULH
    always_comb begin
        op1Neg = (in_op != OP_MULHU) && in_op1[31];
        op2Neg = !in_op[1] && in_op2[31];
        mag1   = op1Neg ? (~in_op1 + 32'd1) : in_op1;
        mag2   = op2Neg ? (~in_op2 + 32'd1) : in_op2;
    end

    Mul32U uMul (
        .a    (s1Mag1),
        .b    (s1Mag2),
        .prod (prod)
    );

    // Negating a zero product wraps back to zero, so -0 never appears
    assign prodFix = s1Neg ? (~prod + 64'd1) : prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid <= 1'b0;
            s1Mag1  <= '0;
            s1Mag2  <= '0;
            s1Neg   <= 1'b0;
            s1Op    <= '0;
            s1Tag   <= '0;
        end else begin
            if (flush) begin
                s1Valid <= 1'b0;
            end else if (s1Adv) begin
                s1Valid <= in_valid;
            end
            if (accept) begin
                s1Mag1 <= mag1;
                s1Mag2 <= mag2;
                s1Neg  <= op1Neg ^ op2Neg;
                s1Op   <= in_op;
                s1Tag  <= in_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2Valid <= 1'b0;
            s2Prod  <= '0;
            s2Op    <= '0;
            s2Tag   <= '0;
        end else begin
            if (flush) begin
                s2Valid <= 1'b0;
            end else if (s2Adv) begin
                s2Valid <= s1Valid;
            end
            if (s2Adv && s1Valid && !flush) begin
                s2Prod <= prodFix;
                s2Op   <= s1Op;
                s2Tag  <= s1Tag;
            end
        end
    end

    assign out_valid = s2Valid;
    assign out_res   = (s2Op == OP_MUL) ? s2Prod[31:0] : s2Prod[63:32];
    assign out_tag   = s2Tag;
    assign busy      = s1Valid || s2Valid;

`ifdef MUL_ISSUE_PERF_CNT_EN
    logic [31:0] perfCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perfCnt <= '0;
        end else if (s2Valid && out_ready) begin
            perfCnt <= perfCnt + 32'd1;
        end
    end

    assign perf_ops = perfCnt;
`endif

endmodule

// File: tb/tb_mul_issue_pipe.sv
// tb/tb_mul_issue_pipe.sv - scoreboard bench for mul_issue_pipe with a 64-bit arithmetic reference model
module tb_mul_issue_pipe;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_op = '0;
    logic [31:0]      in_op1 = '0;
    logic [31:0]      in_op2 = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_res;
    logic [TAG_W-1:0] out_tag;
    logic             busy;
`ifdef MUL_ISSUE_PERF_CNT_EN
    logic [31:0]      perf_ops;
`endif

    mul_issue_pipe #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_op1    (in_op1),
        .in_op2    (in_op2),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_tag   (out_tag),
        .busy      (busy)
`ifdef MUL_ISSUE_PERF_CNT_EN
        ,
        .perf_ops  (perf_ops)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        int               acc;
        bit               lat;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   pops = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Exact product of the operands as the ISA interprets them, reduced mod 2^64
    function automatic logic [31:0] refMul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] x, y, p;
        x = (op == 2'b11) ? {32'd0, a} : {{32{a[31]}}, a};
        y = (op[1] == 1'b0) ? {{32{b[31]}}, b} : {32'd0, b};
        p = x * y;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pickVal();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0001;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic push(input logic [31:0] res, input logic [TAG_W-1:0] tag, input bit lat);
        exp_t e;
        e.res = res;
        e.tag = tag;
        e.acc = cyc;
        e.lat = lat;
        sbq.push_back(e);
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag, input bit lat, input bit useExp,
                         input logic [31:0] expRes);
        int n;
        bit done;
        n = 0;
        done = 0;
        in_op = op; in_op1 = a; in_op2 = b; in_tag = tag; in_valid = 1'b1;
        while (!done && n < 200) begin
            @(negedge clk);
            if (in_ready) begin
                push(useExp ? expRes : refMul(op, a, b), tag, lat);
                done = 1;
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: op %0d not accepted, required acceptance within 200 cycles", op);
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sbq.size());
        end
        @(posedge clk); #1;
    endtask

    // Monitor: pops the scoreboard on every output handshake and checks stall stability
    initial begin
        bit               prevStall;
        logic [31:0]      prevRes;
        logic [TAG_W-1:0] prevTag;
        exp_t             e;
        prevStall = 0;
        prevRes = '0;
        prevTag = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prevStall = 0;
            end else begin
                if (prevStall) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_res", out_res, prevRes);
                    chk("hold_tag", out_tag, prevTag);
                end
                if (out_valid && out_ready) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: got res %h tag %h, required no output", out_res, out_tag);
                    end else begin
                        e = sbq.pop_front();
                        chk("res", out_res, e.res);
                        chk("tag", out_tag, e.tag);
                        if (e.lat) chk("latency", cyc - e.acc, 2);
                        pops++;
                    end
                end
                prevStall = out_valid && !out_ready && !flush;
                prevRes = out_res;
                prevTag = out_tag;
            end
        end
    end

    initial begin
        int  popBase;
        bit  pend;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_res", out_res, 0);
        chk("rst_out_tag", out_tag, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);

        // Back-to-back with latency checks, then corner operands
        out_ready = 1'b1;
        issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 1, 1, 32'hFFFF_FFFE);
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 1, 1, 32'h0000_0001);
        waitDrain();
        issue(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd1, 1, 1, 32'h4000_0000);
        issue(2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 5'd2, 1, 1, 32'hFFFF_FFEB);
        issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1, 1, 32'hFFFF_FFFF);
        issue(2'b10, 32'h0000_0002, 32'h8000_0000, 5'd5, 1, 1, 32'h0000_0001);
        for (int k = 0; k < 4; k++) issue(2'(k), 32'h0, 32'h0, 5'(k + 8), 1, 1, 32'h0);
        issue(2'b00, 32'h0000_0000, 32'h8000_0000, 5'd12, 1, 1, 32'h0);
        waitDrain();

        // Backpressure: two accepts fill the pipe, then in_ready must stay low
        popBase = pops;
        out_ready = 1'b0;
        issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 5'd20, 0, 0, 32'h0);
        issue(2'b10, 32'hDEAD_BEEF, 32'h0000_0003, 5'd21, 0, 0, 32'h0);
        in_op = 2'b00; in_op1 = 32'h0000_0005; in_op2 = 32'h0000_0006; in_tag = 5'd22; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_busy", busy, 1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        issue(2'b00, 32'h0000_0005, 32'h0000_0006, 5'd22, 0, 1, 32'd30);
        issue(2'b11, 32'h8000_0001, 32'hFFFF_FFFE, 5'd23, 0, 0, 32'h0);
        waitDrain();
        chk("bp_count", pops - popBase, 4);

        // Flush with both stages full
        out_ready = 1'b0;
        issue(2'b00, 32'h0000_0011, 32'h0000_0022, 5'd24, 0, 0, 32'h0);
        issue(2'b01, 32'hFFFF_0000, 32'h0001_0000, 5'd25, 0, 0, 32'h0);
        in_op = 2'b00; in_op1 = 32'h0000_0003; in_op2 = 32'h0000_0003; in_tag = 5'd26; in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 0);
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        sbq.delete();
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("flush_no_valid", out_valid, 0);
            chk("flush_busy", busy, 0);
            @(posedge clk); #1;
        end
        issue(2'b00, 32'hFFFF_FFF9, 32'h0000_0003, 5'd27, 1, 1, 32'hFFFF_FFEB);
        waitDrain();

        // Asynchronous reset mid-stream
        issue(2'b00, 32'h0000_0009, 32'h0000_0009, 5'd28, 0, 0, 32'h0);
        issue(2'b11, 32'h0000_0009, 32'h0000_0009, 5'd29, 0, 0, 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
`ifdef MUL_ISSUE_PERF_CNT_EN
        chk("arst_perf", perf_ops, 0);
`endif
        sbq.delete();
        @(negedge clk);
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("arst_no_valid", out_valid, 0);
        end
        @(posedge clk); #1;
        issue(2'b01, 32'h8000_0000, 32'h7FFF_FFFF, 5'd30, 1, 0, 32'h0);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd31, 1, 0, 32'h0);
        issue(2'b00, 32'h0001_0001, 32'h0001_0001, 5'd0, 1, 1, 32'h0002_0001);
        waitDrain();
`ifdef MUL_ISSUE_PERF_CNT_EN
        chk("perf_after3", perf_ops, 3);
`endif

        // Randomized traffic with random backpressure
        pend = 0;
        for (int c = 0; c < 800; c++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                in_op = 2'($urandom_range(0, 3));
                in_op1 = pickVal();
                in_op2 = pickVal();
                in_tag = TAG_W'($urandom);
                in_valid = 1'b1;
                pend = 1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) begin
                push(refMul(in_op, in_op1, in_op2), in_tag, 0);
                pend = 0;
            end
            @(posedge clk); #1;
            if (!pend) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        waitDrain();
        chk("sb_empty", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
